pc_sequencer: RTL and testbench

- Fetch/decode/execute controller for the 2-bit program counter datapath.
- Requests instructions from instruction memory and sequences the adder with one-cycle enables.
- Latches the adder overflow into a status flag and advances the PC: increment with wrap, or JNO branch.
- Replaces the ad-hoc monostable pulse timing with synchronous single-cycle strobes.

---
 rtl/pc_seq_pkg.sv | 21 ++
 rtl/pc_next_unit.sv | 31 +++
 rtl/pc_sequencer.sv | 142 ++++++++++++++
 tb/tb_pc_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: FSM state encodings and
// instruction opcodes.
package pc_seq_pkg;

  localparam int unsigned OPC_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  localparam logic [OPC_W-1:0] OP_ADD = 2'b00;
  localparam logic [OPC_W-1:0] OP_JNO = 2'b01;
  localparam logic [OPC_W-1:0] OP_NOP = 2'b10;
  localparam logic [OPC_W-1:0] OP_HLT = 2'b11;

endpackage

// File: rtl/pc_next_unit.sv
// Next-PC selection: increment with wrap, JNO branch, or hold for HLT.
// Ports: pc/operand (PC_W), ovf_flag, opcode (2) in; next_pc (PC_W) out,
// combinational.
module pc_next_unit
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W = 2
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [PC_W-1:0]  operand,
  input  logic             ovf_flag,
  input  logic [OPC_W-1:0] opcode,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] pc_inc;

  // Natural wrap modulo 2^PC_W; no carry out is kept.
  assign pc_inc = pc + PC_W'(1);

  // Branch taken only when no overflow is latched.
  always_comb begin
    next_pc = pc_inc;
    if (opcode == OP_JNO && !ovf_flag) begin
      next_pc = operand;
    end else if (opcode == OP_HLT) begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/execute controller for the small PC datapath.
// Ports: clk, rst_n, start in; imem_req/imem_addr out, imem_ack/imem_data in;
// alu_en out, alu_ovf in; reg_we, pc, ovf_flag, halted, fault, retired out.
// All outputs come straight from flops.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned PC_W        = 2,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [PC_W+1:0]   imem_data,
  output logic              alu_en,
  input  logic              alu_ovf,
  output logic              reg_we,
  output logic [PC_W-1:0]   pc,
  output logic              ovf_flag,
  output logic              halted,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  localparam int unsigned IR_W  = PC_W + OPC_W;
  localparam int unsigned TMR_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t             state, state_d;
  logic [IR_W-1:0]    ir, ir_d;
  logic [TMR_W-1:0]   timer, timer_d;
  logic [PC_W-1:0]    pc_d, next_pc;
  logic               ovf_d, fault_d, retire;
  logic [CNT_W-1:0]   retired_d;
  logic [OPC_W-1:0]   opcode;

  assign opcode    = ir[IR_W-1:PC_W];
  assign imem_addr = pc;

  pc_next_unit #(.PC_W(PC_W)) u_next (
    .pc       (pc),
    .operand  (ir[PC_W-1:0]),
    .ovf_flag (ovf_flag),
    .opcode   (opcode),
    .next_pc  (next_pc)
  );

  // Next-state and datapath update decisions.
  always_comb begin
    state_d = state;
    ir_d    = ir;
    timer_d = timer;
    pc_d    = pc;
    ovf_d   = ovf_flag;
    fault_d = fault;
    retire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // An ack arriving on the timeout cycle still completes the fetch.
        if (imem_ack) begin
          ir_d    = imem_data;
          timer_d = '0;
          state_d = ST_DECODE;
        end else if (timer == TMR_W'(ACK_TIMEOUT)) begin
          timer_d = '0;
          fault_d = 1'b1;
          state_d = ST_HALT;
        end else begin
          timer_d = timer + TMR_W'(1);
        end
      end
      ST_DECODE: begin
        case (opcode)
          OP_ADD: state_d = ST_EXEC;
          OP_HLT: begin
            retire  = 1'b1;
            state_d = ST_HALT;
          end
          default: begin
            pc_d    = next_pc;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        ovf_d   = alu_ovf;
        pc_d    = next_pc;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        if (start) begin
          pc_d    = '0;
          fault_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    retired_d = retired;
    if (retire && retired != '1) retired_d = retired + CNT_W'(1);
  end

  // State, datapath and strobe registers; strobes are decoded from the
  // next state so each is high exactly while the FSM sits in its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ir       <= '0;
      timer    <= '0;
      pc       <= '0;
      ovf_flag <= 1'b0;
      fault    <= 1'b0;
      retired  <= '0;
      imem_req <= 1'b0;
      alu_en   <= 1'b0;
      reg_we   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      state    <= state_d;
      ir       <= ir_d;
      timer    <= timer_d;
      pc       <= pc_d;
      ovf_flag <= ovf_d;
      fault    <= fault_d;
      retired  <= retired_d;
      imem_req <= (state_d == ST_FETCH);
      alu_en   <= (state_d == ST_EXEC);
      reg_we   <= (state_d == ST_WB);
      halted   <= (state_d == ST_HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against an instruction-level model.
module tb_pc_sequencer;

  localparam int unsigned PC_W  = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [PC_W+1:0]  imem_data;
  logic             alu_en;
  logic             alu_ovf;
  logic             reg_we;
  logic [PC_W-1:0]  pc;
  logic             ovf_flag;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;

  pc_sequencer #(.PC_W(PC_W), .ACK_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .alu_en(alu_en), .alu_ovf(alu_ovf),
    .reg_we(reg_we), .pc(pc), .ovf_flag(ovf_flag), .halted(halted),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int n_alu   = 0;
  int n_we    = 0;
  int n_both  = 0;

  // Instruction-level model state.
  int m_pc  = 0;
  int m_ovf = 0;
  int m_ret = 0;

  localparam logic [1:0] I_ADD = 2'b00, I_JNO = 2'b01, I_NOP = 2'b10, I_HLT = 2'b11;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Strobe pulse counters and overlap detector.
  always @(negedge clk) begin
    if (alu_en) n_alu++;
    if (reg_we) n_we++;
    if (alu_en && reg_we) n_both++;
  end

  task automatic model_retire();
    if (m_ret < 255) m_ret++;
  endtask

  task automatic check_arch(input string tag);
    check({tag, "_pc"}, 32'(pc), m_pc);
    check({tag, "_ovf"}, 32'(ovf_flag), m_ovf);
    check({tag, "_ret"}, 32'(retired), m_ret);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8; i++) begin
      if (imem_req) break;
      @(negedge clk);
    end
    check("fetch_return", 32'(imem_req), 1);
  endtask

  // Run one instruction from a negedge in FETCH; ack after dly idle cycles.
  task automatic exec_one(input logic [1:0] op, input logic [1:0] opnd,
                          input int dly, input logic ovf_in);
    check("fetch_req", 32'(imem_req), 1);
    check("fetch_addr", 32'(imem_addr), m_pc);
    check_arch("pre");
    repeat (dly) @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = {op, opnd};
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 4'($urandom);
    case (op)
      I_ADD: begin
        @(negedge clk);
        check("exec_alu_en", 32'(alu_en), 1);
        check("exec_reg_we", 32'(reg_we), 0);
        alu_ovf = ~ovf_in;
        start   = 1'($urandom);
        @(negedge clk);
        check("wb_reg_we", 32'(reg_we), 1);
        check("wb_alu_en", 32'(alu_en), 0);
        alu_ovf = ovf_in;
        start   = 1'($urandom);
        @(negedge clk);
        alu_ovf = 1'b0;
        start   = 1'b0;
        m_ovf = int'(ovf_in);
        m_pc  = (m_pc + 1) % 4;
        model_retire();
        check("add_latency", 32'(imem_req), 1);
        check("add_strobes_off", 32'({alu_en, reg_we}), 0);
      end
      I_JNO, I_NOP: begin
        if (op == I_JNO && m_ovf == 0) m_pc = int'(opnd);
        else m_pc = (m_pc + 1) % 4;
        model_retire();
        wait_req();
      end
      default: begin
        model_retire();
        @(negedge clk);
        check("hlt_halted", 32'(halted), 1);
        check("hlt_req", 32'(imem_req), 0);
      end
    endcase
    check_arch("post");
  endtask

  task automatic restart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 0;
    check("restart_req", 32'(imem_req), 1);
    check("restart_fault", 32'(fault), 0);
    check("restart_halted", 32'(halted), 0);
    check_arch("restart");
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({imem_req, alu_en, reg_we, ovf_flag, halted, fault}), 0);
    check({tag, "_pc"}, 32'(pc), 0);
    check({tag, "_ret"}, 32'(retired), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, w0;
    logic [1:0] op;
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_data = '0; alu_ovf = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req", 32'(imem_req), 0);
    restart();

    // ADD, ADD, NOP, HLT
    a0 = n_alu; w0 = n_we;
    exec_one(I_ADD, 2'd0, 0, 1'b0);
    exec_one(I_ADD, 2'd0, 0, 1'b0);
    exec_one(I_NOP, 2'd0, 0, 1'b0);
    exec_one(I_HLT, 2'd0, 0, 1'b0);
    check("progA_pc", 32'(pc), 3);
    check("progA_ret", 32'(retired), 4);
    check("progA_alu_pulses", 32'(n_alu - a0), 2);
    check("progA_we_pulses", 32'(n_we - w0), 2);

    // JNO not taken after overflow, then taken without overflow.
    restart();
    exec_one(I_ADD, 2'd0, 0, 1'b1);
    exec_one(I_JNO, 2'd0, 0, 1'b0);
    check("jno_not_taken", 32'(pc), 2);
    exec_one(I_HLT, 2'd0, 0, 1'b0);
    restart();
    exec_one(I_ADD, 2'd0, 0, 1'b0);
    exec_one(I_JNO, 2'd0, 0, 1'b0);
    check("jno_taken", 32'(pc), 0);

    // NOP wrap with a set flag left untouched.
    exec_one(I_ADD, 2'd3, 0, 1'b1);
    for (int i = 0; i < 4; i++) exec_one(I_NOP, 2'($urandom), 0, 1'b0);
    check("wrap_pc", 32'(pc), 1);
    check("wrap_ovf", 32'(ovf_flag), 1);

    // Random program with random ack delays.
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      exec_one(op, 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      if (op == I_HLT) restart();
    end

    // Fetch timeout: 16 cycles without ack.
    for (int i = 0; i < 15; i++) @(negedge clk);
    check("tmo_still_req", 32'(imem_req), 1);
    check("tmo_no_fault_yet", 32'(fault), 0);
    @(negedge clk);
    check("tmo_fault", 32'(fault), 1);
    check("tmo_halted", 32'(halted), 1);
    check("tmo_req_off", 32'(imem_req), 0);
    restart();
    // Ack on the timeout cycle itself.
    exec_one(I_NOP, 2'd0, 15, 1'b0);
    check("late_ack_fault", 32'(fault), 0);

    // Reset in the middle of EXEC.
    w0 = n_we;
    imem_ack = 1'b1; imem_data = {I_ADD, 2'd0};
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    check("rst_pre_alu_en", 32'(alu_en), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_no_we", 32'(n_we - w0), 0);
    m_pc = 0; m_ovf = 0; m_ret = 0;
    @(negedge clk);
    check("midrst_idle", 32'(imem_req), 0);

    // Saturation of the retired counter.
    restart();
    for (int i = 0; i < 300; i++) exec_one(I_NOP, 2'($urandom), 0, 1'b0);
    check("sat_ret", 32'(retired), 255);

    check("strobe_overlap", 32'(n_both), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
